fib_result_collector: RTL and testbench
=======================================

Name: fib_result_collector

Overview:
- Downstream stage of the Fibonacci generator.
- Captures each completed result pair (n, fib) on the generator's done strobe into a small first-word-fall-through FIFO.
- Presents results to the consumer over a valid/ready interface.
- The generator has no backpressure, so results arriving while the FIFO is full are dropped and flagged with a sticky overflow bit.

Parameters:
- WIDTH, 8, bit width of n and fib, matching the generator's WIDTH.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  one-cycle done strobe from the generator; result pair valid this cycle
- in_n  input  WIDTH  index n of the completed result
- in_fib  input  WIDTH  Fibonacci value for in_n
- in_ready  output  1  high when the FIFO is not full (informational; the generator ignores it)
- out_valid  output  1  FIFO non-empty
- out_n  output  WIDTH  n of the head entry
- out_fib  output  WIDTH  fib of the head entry
- out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both high
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky flag: a result was dropped while full
- clear_ovf  input  1  one-cycle pulse that clears overflow

Behaviour:
- One clock; reset is synchronous and active-low.
  - rst_n sampled low at a clk edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Resulting outputs: out_valid=0, in_ready=1, out_n=0, out_fib=0.
  - Memory contents are don't-care but never visible while empty.
- Reset mid-operation:
  - All pending entries are discarded.
  - An in_valid in the same cycle as reset is ignored.
- Push: on an edge with in_valid=1 and count<DEPTH:
  - {in_n, in_fib} is written at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: on an edge with out_valid=1 and out_ready=1, rd_ptr increments modulo DEPTH.
- Occupancy:
  - count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
  - count never exceeds DEPTH and never underflows.
- Latency:
  - A pushed entry into an empty FIFO appears on out_valid/out_n/out_fib in the cycle after the push edge.
  - No combinational path from in_* to out_*.
- Output data:
  - FWFT: out_n/out_fib are read combinationally from memory at rd_ptr.
  - Both are forced to 0 when empty.
- Ready/valid rules:
  - in_ready = (count != DEPTH), purely from registered state.
  - No pass-through when full: in_valid while full is dropped even if a pop occurs in the same cycle.
  - In that case overflow is set and the pop still completes.
- Overflow:
  - Set on any edge with in_valid=1 and count==DEPTH.
  - Cleared on clear_ovf=1.
  - If set and clear occur in the same cycle, set wins.
  - Only reset or clear_ovf clears it.
- Empty plus in_valid: the push occurs; out_valid rises next cycle. A pop cannot occur while empty.
- Pointers wrap naturally using DEPTH power of two, $clog2(DEPTH) bits; count carries full/empty disambiguation.
- Arithmetic: no width conversion; values stored exactly as received.

Optional Feature:
- Macro: FIB_RESULT_TOTAL_EN.
- With the macro defined:
  - Adds output port total  16 bits: count of accepted pushes since reset.
  - Increments by one per accepted push and wraps 0xFFFF->0x0000.
  - Dropped results are not counted.
  - Reset value 0.
- Without it:
  - The port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package fib_pkg:
  - FIB_WIDTH default 8.
  - Packed struct fib_result_t {n, fib} used as the FIFO entry type.
  - The generator adopts the same package.
- One natural sub-module: fib_fifo_mem.
  - DEPTH x fib_result_t register array.
  - Synchronous write port, asynchronous read port.
  - Parameterised on DEPTH.
- Pointer, count and flag logic stays in the top.

Test Plan:
- Reset check: hold rst_n=0 two cycles -> out_valid=0, count=0, overflow=0, in_ready=1, out_n=0, out_fib=0.
- Single result: in_valid pulse with n=5, fib=5, out_ready=0 -> next cycle out_valid=1, out_n=5, out_fib=5, count=1; out_ready=1 one cycle -> out_valid=0, count=0.
- Fill and order: push (5,5),(10,55),(0,0),(7,13) with DEPTH=4 -> count=4, in_ready=0; drain -> results emerge in push order; in_ready returns to 1 after the first pop.
- Overflow while full: fifth push (12,144) with simultaneous pop -> entry dropped, overflow=1, count=3; clear_ovf pulse -> overflow=0; clear_ovf together with another full-drop -> overflow stays 1.
- Simultaneous push/pop at count=2 -> count stays 2, head advances, wr_ptr wraps correctly across 6 iterations.
- Reset mid-stream: rst_n low with count=3 and in_valid=1 -> count=0, out_valid=0, incoming pair discarded; with FIB_RESULT_TOTAL_EN, total=0 after reset and equals the number of accepted pushes otherwise.

Source files
------------

// File: rtl/fib_pkg.sv
// fib_pkg -- types and constants shared by the Fibonacci generator and its
// downstream result collector.
//
// Contents:
//   FIB_WIDTH     default bit width of n and fib.
//   TOTAL_W       width of the optional accepted-result counter.
//   fib_result_t  packed {n, fib} pair; this is the FIFO entry format.
package fib_pkg;

  localparam int FIB_WIDTH = 8;
  localparam int TOTAL_W   = 16;

  typedef struct packed {
    logic [FIB_WIDTH-1:0] n;
    logic [FIB_WIDTH-1:0] fib;
  } fib_result_t;

endpackage : fib_pkg

// File: rtl/fib_fifo_mem.sv
// fib_fifo_mem -- DEPTH-entry storage for fib_result_t pairs.
//
// It has one synchronous write port and one asynchronous read port. The
// asynchronous read lets the collector present its head entry
// first-word-fall-through, with no extra cycle of latency. There is no reset.
// The collector never shows the contents of an empty FIFO, so stale data
// cannot leak out.
//
// Ports:
//   clk      in   rising-edge clock
//   wr_en    in   write wr_data at wr_addr on this edge
//   wr_addr  in   write address, ADDR_W bits
//   wr_data  in   entry to store
//   rd_addr  in   read address, ADDR_W bits
//   rd_data  out  entry at rd_addr (combinational)
module fib_fifo_mem
  import fib_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  fib_result_t       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output fib_result_t       rd_data
);

  fib_result_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : fib_fifo_mem

// File: rtl/fib_result_collector.sv
// fib_result_collector -- the downstream stage of the Fibonacci generator.
//
// On each done strobe from the generator, this block captures the completed
// (n, fib) pair into a small first-word-fall-through FIFO. The consumer drains
// the FIFO over a valid/ready interface. The generator cannot be stalled, so a
// result that arrives while the FIFO is full is dropped. The sticky overflow
// flag records that a drop happened.
//
// Optional build macro:
//   FIB_RESULT_TOTAL_EN  adds the 16-bit output 'total'. It counts the pushes
//                        accepted since reset and wraps at 0xFFFF.
//
// Parameters:
//   WIDTH  bit width of n and fib. It must equal fib_pkg::FIB_WIDTH, because
//          the entries are stored as fib_result_t.
//   DEPTH  number of FIFO entries; a power of two, minimum 2.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   one-cycle done strobe; in_n/in_fib are valid
//   in_n       in   index n of the result
//   in_fib     in   Fibonacci value for in_n
//   in_ready   out  FIFO not full (informational only)
//   out_valid  out  FIFO non-empty
//   out_n      out  n of the head entry (0 when empty)
//   out_fib    out  fib of the head entry (0 when empty)
//   out_ready  in   consumer takes the head when out_valid is also high
//   count      out  current occupancy, 0..DEPTH
//   overflow   out  sticky: a result was dropped while full
//   total      out  (FIB_RESULT_TOTAL_EN only) accepted-push counter
//   clear_ovf  in   one-cycle pulse that clears overflow
module fib_result_collector
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_n,
  input  logic [WIDTH-1:0]           in_fib,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_n,
  output logic [WIDTH-1:0]           out_fib,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
`ifdef FIB_RESULT_TOTAL_EN
  output logic [TOTAL_W-1:0]         total,
`endif
  input  logic                       clear_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  fib_result_t wr_entry;
  fib_result_t head_entry;

  // Full and empty come only from registered occupancy. This keeps in_ready
  // and out_valid free of any combinational path from the inputs.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A push is never allowed while full, even if a pop frees a slot on the
  // same edge. A pop can happen only when an entry is actually presented.
  assign push = in_valid && !full;
  assign pop  = !empty && out_ready;

  assign wr_entry.n   = in_n;
  assign wr_entry.fib = in_fib;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // When a push and a pop coincide, the occupancy stays the same.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as clear_ovf must keep the flag set, so the
    // set term is tested last and takes priority.
    if (clear_ovf) begin
      overflow_d = 1'b0;
    end
    if (in_valid && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // A write during reset is suppressed. The pointers reset anyway, but this
  // keeps the memory from changing while the in_valid is being ignored.
  fib_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && rst_n),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head_entry)
  );

`ifdef FIB_RESULT_TOTAL_EN
  logic [TOTAL_W-1:0] total_q, total_d;

  // Only accepted pushes are counted; dropped results are not.
  always_comb begin
    total_d = total_q;
    if (push) begin
      total_d = total_q + TOTAL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;
`endif

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // The head is forced to zero when the FIFO is empty, so stale memory
  // contents never appear on the outputs.
  assign out_n   = empty ? '0 : head_entry.n;
  assign out_fib = empty ? '0 : head_entry.fib;

endmodule : fib_result_collector

// File: tb/tb_fib_result_collector.sv
module tb_fib_result_collector;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] fib;
  } pair_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] in_fib;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_n;
  logic [WIDTH-1:0] out_fib;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clear_ovf;
`ifdef FIB_RESULT_TOTAL_EN
  logic [15:0]      total;
`endif

  always #5 clk = ~clk;

  fib_result_collector #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_n      (in_n),
    .in_fib    (in_fib),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_n     (out_n),
    .out_fib   (out_fib),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
`ifdef FIB_RESULT_TOTAL_EN
    .total     (total),
`endif
    .clear_ovf (clear_ovf)
  );

  // Reference model: an ordered queue of accepted results plus the flags
  int          vectors     = 0;
  int          miscompares = 0;
  pair_t       m_q[$];
  bit          m_ovf       = 1'b0;
  logic [15:0] m_total     = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge, then
  // compare every output 1 time unit after the edge.
  task automatic tick(input logic iv, input logic [7:0] n, input logic [7:0] f,
                      input logic ordy, input logic clr, input logic rstn);
    bit    was_full;
    bit    do_pop;
    pair_t p;
    @(negedge clk);
    in_valid  = iv;
    in_n      = n;
    in_fib    = f;
    out_ready = ordy;
    clear_ovf = clr;
    rst_n     = rstn;
    @(posedge clk);
    if (!rstn) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_total = 16'd0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() != 0) && ordy;
      if (iv && was_full) m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      if (do_pop) void'(m_q.pop_front());
      if (iv && !was_full) begin
        p.n   = n;
        p.fib = f;
        m_q.push_back(p);
        m_total = m_total + 16'd1;
      end
    end
    #1;
    check("count",     32'(count),     32'(m_q.size()));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("in_ready",  32'(in_ready),  32'(m_q.size() != DEPTH));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("out_n",     32'(out_n),     (m_q.size() != 0) ? 32'(m_q[0].n)   : 32'd0);
    check("out_fib",   32'(out_fib),   (m_q.size() != 0) ? 32'(m_q[0].fib) : 32'd0);
`ifdef FIB_RESULT_TOTAL_EN
    check("total",     32'(total),     32'(m_total));
`endif
    $display("cyc rst_n=%0b in_valid=%0b in=(%0d,%0d) out_ready=%0b clr=%0b -> count=%0d out_valid=%0b out=(%0d,%0d) ovf=%0b",
             rstn, iv, n, f, ordy, clr, count, out_valid, out_n, out_fib, overflow);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_n      = '0;
    in_fib    = '0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;

    // Reset held for two cycles
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);

    // Single result, held and then consumed
    tick(1, 5, 5, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 1);

    // Fill to DEPTH; order is checked while draining below
    tick(1, 5, 5, 0, 0, 1);
    tick(1, 10, 55, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 7, 13, 0, 0, 1);

    // Push while full with a simultaneous pop: the push is dropped
    tick(1, 12, 144, 1, 0, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(1, 20, 109, 0, 0, 1);
    // A clear on the same edge as a drop: the flag stays set
    tick(1, 21, 110, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);

    // Drain: results must come out in push order
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0, 1);

    // Simultaneous push and pop at count 2, enough times to wrap the pointers
    tick(1, 1, 1, 0, 0, 1);
    tick(1, 2, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick(1, 8'(3 + i), 8'(40 + i), 1, 0, 1);
    tick(0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 1, 0, 1);

    // Reset in mid-stream with count 3 and in_valid high
    tick(1, 30, 31, 0, 0, 1);
    tick(1, 32, 33, 0, 0, 1);
    tick(1, 34, 35, 0, 0, 1);
    tick(1, 99, 99, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 49) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fib_result_collector
